// File: rtl/enc_pwm_mixer_if.sv
// Bus bundle for enc_pwm_mixer: enable, encoder pins in, PWM and level outputs.
// The master side drives the encoder pins and enable; the slave is the mixer.
interface enc_pwm_mixer_if #(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = 8
);
  logic                    ena;
  logic [NUM_CH-1:0]       enc_a;
  logic [NUM_CH-1:0]       enc_b;
  logic [NUM_CH-1:0]       pwm_out;
  logic [NUM_CH*WIDTH-1:0] level_out;
  logic                    period_start;

  modport master (output ena, enc_a, enc_b, input pwm_out, level_out, period_start);
  modport slave  (input ena, enc_a, enc_b, output pwm_out, level_out, period_start);
endinterface

// File: rtl/enc_pwm_mixer.sv
// NUM_CH quadrature encoders -> synchroniser, debouncer, A-rising-edge decoder,
// WIDTH-bit level register and period-latched glitch-free PWM per channel.
module enc_pwm_mixer #(
  parameter int NUM_CH      = 3,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int STEP        = 1,
  parameter int SATURATE    = 1
) (
  input logic           clk,
  input logic           rst_n,
  enc_pwm_mixer_if.slave bus
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);

  logic [2*NUM_CH-1:0] raw;
  logic [2*NUM_CH-1:0] deb;
  logic [WIDTH-1:0]    cnt;
  logic                ps_q;

  // Pins 0..NUM_CH-1 are A, NUM_CH..2*NUM_CH-1 are B; all share one debouncer shape.
  assign raw = {bus.enc_b, bus.enc_a};

  for (genvar p = 0; p < 2 * NUM_CH; p++) begin : g_pin
    logic [SYNC_STAGES-1:0] sh;
    logic [DW-1:0]          dc;
    logic                   d_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh  <= '0;
        dc  <= '0;
        d_q <= 1'b0;
      end else begin
        sh <= {sh[SYNC_STAGES-2:0], raw[p]};
        if (bus.ena) begin
          if (sh[SYNC_STAGES-1] == d_q) begin
            dc <= '0;
          end else if (dc == DW'(DEB_CYCLES - 1)) begin
            dc  <= '0;
            d_q <= sh[SYNC_STAGES-1];
          end else begin
            dc <= dc + 1'b1;
          end
        end
      end
    end

    assign deb[p] = d_q;
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [WIDTH-1:0] lvl_q, duty_q, inc, dec;
    logic [WIDTH:0]   sum, diff;
    logic             prev_q, pwm_q;

    // Extra MSB of sum/diff is the carry/borrow used for clamping.
    always_comb begin
      sum  = {1'b0, lvl_q} + STEP_W;
      diff = {1'b0, lvl_q} - STEP_W;
      inc  = (SATURATE != 0 && sum[WIDTH])  ? '1 : sum[WIDTH-1:0];
      dec  = (SATURATE != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev_q <= 1'b0;
        lvl_q  <= '0;
        duty_q <= '0;
        pwm_q  <= 1'b0;
      end else if (bus.ena) begin
        prev_q <= deb[ch];
        if (deb[ch] && !prev_q) lvl_q <= deb[NUM_CH+ch] ? dec : inc;
        if (&cnt) duty_q <= lvl_q;
        pwm_q <= (cnt < duty_q);
      end else begin
        pwm_q <= 1'b0;
      end
    end

    assign bus.pwm_out[ch]                 = pwm_q;
    assign bus.level_out[ch*WIDTH +: WIDTH] = lvl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      ps_q <= 1'b0;
    end else if (bus.ena) begin
      cnt  <= cnt + 1'b1;
      ps_q <= (cnt == '0);
    end else begin
      ps_q <= 1'b0;
    end
  end

  assign bus.period_start = ps_q;
endmodule

// File: tb/tb_enc_pwm_mixer.sv
// Bench for enc_pwm_mixer: three configurations checked against a level/PWM model
// built from the detent, clamp/wrap and period-latched duty rules.
module tb_enc_pwm_mixer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  enc_pwm_mixer_if #(.NUM_CH(3), .WIDTH(8)) ifa ();
  enc_pwm_mixer_if #(.NUM_CH(1), .WIDTH(8)) ifb ();
  enc_pwm_mixer_if #(.NUM_CH(8), .WIDTH(4)) ifc ();

  enc_pwm_mixer #(.NUM_CH(3), .WIDTH(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  enc_pwm_mixer #(.NUM_CH(1), .WIDTH(8), .STEP(16), .SATURATE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  enc_pwm_mixer #(.NUM_CH(8), .WIDTH(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int errors = 0;
  int checks = 0;
  int exp_lvl [3][8];
  int duty    [3][8];
  int ph      [3];
  logic [7:0] epwm [3];
  logic       eps  [3];
  logic [7:0] cur_a [3];
  logic [7:0] cur_b [3];

  function automatic int per(int s);  return (s == 2) ? 16 : 256; endfunction
  function automatic int stp(int s);  return (s == 1) ? 16 : 1;   endfunction
  function automatic bit sat(int s);  return s != 1;              endfunction
  function automatic int nch(int s);  return (s == 0) ? 3 : (s == 1) ? 1 : 8; endfunction

  function automatic logic en(int s);
    case (s)
      0: return ifa.ena;
      1: return ifb.ena;
      default: return ifc.ena;
    endcase
  endfunction

  function automatic logic [7:0] pwm_of(int s);
    case (s)
      0: return {5'b0, ifa.pwm_out};
      1: return {7'b0, ifb.pwm_out};
      default: return ifc.pwm_out;
    endcase
  endfunction

  function automatic logic ps_of(int s);
    case (s)
      0: return ifa.period_start;
      1: return ifb.period_start;
      default: return ifc.period_start;
    endcase
  endfunction

  function automatic logic [31:0] lvl(int s, int ch);
    case (s)
      0: return {24'b0, ifa.level_out[ch*8 +: 8]};
      1: return {24'b0, ifb.level_out[7:0]};
      default: return {28'b0, ifc.level_out[ch*4 +: 4]};
    endcase
  endfunction

  function automatic int next_lvl(int s, int cur, bit down);
    int v;
    v = down ? cur - stp(s) : cur + stp(s);
    if (sat(s)) begin
      if (v < 0) v = 0;
      if (v > per(s) - 1) v = per(s) - 1;
    end else begin
      v = (v + per(s)) % per(s);
    end
    return v;
  endfunction

  // PWM reference: phase counts enabled clocks since reset; duty is the level at period end.
  always @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (!rst_n) begin
        ph[s] = 0; eps[s] = 1'b0; epwm[s] = '0;
        for (int ch = 0; ch < 8; ch++) duty[s][ch] = 0;
      end else if (en(s)) begin
        eps[s] = (ph[s] == 0);
        for (int ch = 0; ch < 8; ch++) epwm[s][ch] = (ph[s] < duty[s][ch]);
        if (ph[s] == per(s) - 1)
          for (int ch = 0; ch < 8; ch++) duty[s][ch] = exp_lvl[s][ch];
        ph[s] = (ph[s] + 1) % per(s);
      end else begin
        eps[s] = 1'b0; epwm[s] = '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input int s);
    case (s)
      0: begin ifa.enc_a = cur_a[0][2:0]; ifa.enc_b = cur_b[0][2:0]; end
      1: begin ifb.enc_a = cur_a[1][0:0]; ifb.enc_b = cur_b[1][0:0]; end
      default: begin ifc.enc_a = cur_a[2]; ifc.enc_b = cur_b[2]; end
    endcase
  endtask

  task automatic cyc(input int s);
    @(negedge clk);
    chk("pwm", {24'b0, pwm_of(s)}, {24'b0, epwm[s]});
    chk("period_start", {31'b0, ps_of(s)}, {31'b0, eps[s]});
  endtask

  task automatic wait_pwm(input int s, input int n);
    repeat (n) cyc(s);
  endtask

  task automatic setb(input int s, input logic [7:0] bmask);
    cur_b[s] = bmask;
    drive(s);
    wait_pwm(s, 8);
  endtask

  task automatic chk_lvls(input int s, input string tag);
    for (int ch = 0; ch < nch(s); ch++) chk(tag, lvl(s, ch), exp_lvl[s][ch]);
  endtask

  // Raw A high for hi cycles then low for lo (>=7); level moves 7 clocks after the rise.
  task automatic pulse(input int s, input logic [7:0] amask_in, input int hi, input int lo, input bit lat);
    int nl [8];
    logic [7:0] amask;
    bit live;
    amask = amask_in & 8'((1 << nch(s)) - 1);
    live  = en(s) && (hi >= 4);
    for (int ch = 0; ch < 8; ch++)
      nl[ch] = (amask[ch] && live) ? next_lvl(s, exp_lvl[s][ch], cur_b[s][ch]) : exp_lvl[s][ch];
    cur_a[s] = amask;
    drive(s);
    for (int k = 1; k <= hi + lo; k++) begin
      cyc(s);
      if (k == hi) begin cur_a[s] = '0; drive(s); end
      if (k == 7) for (int ch = 0; ch < 8; ch++) exp_lvl[s][ch] = nl[ch];
      if (lat && (k == 6 || k == 7))
        for (int ch = 0; ch < nch(s); ch++)
          if (amask[ch]) chk((k == 6) ? "lat_before" : "lat_after", lvl(s, ch), exp_lvl[s][ch]);
    end
  endtask

  task automatic count_high(input int s, input int ch, input int n, input int expv);
    int c;
    logic [7:0] v;
    c = 0;
    repeat (n) begin
      cyc(s);
      v = pwm_of(s);
      c += int'(v[ch]);
    end
    chk("duty_count", c, expv);
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.ena = 1'b1; ifb.ena = 1'b1; ifc.ena = 1'b1;
    for (int s = 0; s < 3; s++) begin
      cur_a[s] = '0; cur_b[s] = '0; drive(s);
      for (int ch = 0; ch < 8; ch++) exp_lvl[s][ch] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_pwm_a", {29'b0, ifa.pwm_out}, 0);
    chk("rst_ps_a", {31'b0, ifa.period_start}, 0);
    chk("rst_lvl_a", {8'b0, ifa.level_out}, 0);
    chk("rst_lvl_c", ifc.level_out, 0);
    rst_n = 1'b1;
    cyc(0);
    chk("first_ps", {31'b0, ifa.period_start}, 1);

    // Counting with exact latency on ch0
    setb(0, 8'h00);
    repeat (5) pulse(0, 8'h01, 10, 10, 1);
    chk("count_up", lvl(0, 0), 5);
    setb(0, 8'h01);
    repeat (2) pulse(0, 8'h01, 10, 10, 1);
    chk("count_down", lvl(0, 0), 3);
    chk("ch1_idle", lvl(0, 1), 0);
    chk("ch2_idle", lvl(0, 2), 0);

    // Debounce: short pulse lost, minimum pulse counts, bounce counts once
    setb(0, 8'h00);
    pulse(0, 8'h01, 3, 10, 1);
    chk("deb_short", lvl(0, 0), 3);
    pulse(0, 8'h01, 4, 10, 1);
    chk("deb_min", lvl(0, 0), 4);
    cur_a[0] = 8'h01; drive(0); cyc(0);
    cur_a[0] = 8'h00; drive(0); cyc(0);
    pulse(0, 8'h01, 8, 10, 1);
    chk("deb_bounce", lvl(0, 0), 5);

    // Clamp at zero, then shared edges on ch1/ch2
    setb(0, 8'h02);
    pulse(0, 8'h02, 8, 8, 1);
    chk("sat_low", lvl(0, 1), 0);
    setb(0, 8'h00);
    repeat (64) pulse(0, 8'h06, 8, 8, 0);
    chk_lvls(0, "multi_lvl");
    wait_pwm(0, 300);
    count_high(0, 1, 256, 64);

    // Level change spanning periods; per-cycle PWM compare covers the boundary
    repeat (64) pulse(0, 8'h02, 8, 8, 0);
    wait_pwm(0, 260);
    count_high(0, 1, 256, 128);

    repeat (191) pulse(0, 8'h04, 8, 8, 0);
    pulse(0, 8'h04, 8, 8, 1);
    chk("reach_max", lvl(0, 2), 255);
    pulse(0, 8'h04, 8, 8, 1);
    chk("sat_high", lvl(0, 2), 255);

    // Disable: outputs low, edges lost, counter held
    ifa.ena = 1'b0;
    setb(0, 8'h05);
    repeat (16) pulse(0, 8'h07, 8, 8, 0);
    cur_b[0] = '0; drive(0);
    wait_pwm(0, 36);
    chk("ena_lvl0", lvl(0, 0), 5);
    chk("ena_lvl1", lvl(0, 1), 128);
    chk("ena_lvl2", lvl(0, 2), 255);
    ifa.ena = 1'b1;
    wait_pwm(0, 300);
    pulse(0, 8'h01, 8, 8, 1);
    chk("ena_resume", lvl(0, 0), 6);

    // Wrap with STEP=16
    setb(1, 8'h01);
    pulse(1, 8'h01, 8, 8, 1);
    chk("wrap_down", lvl(1, 0), 240);
    setb(1, 8'h00);
    repeat (2) pulse(1, 8'h01, 8, 8, 1);
    chk("wrap_up", lvl(1, 0), 16);
    wait_pwm(1, 300);

    // Eight channels, randomized masks, directions and pulse lengths
    repeat (24) begin
      setb(2, 8'($urandom));
      pulse(2, 8'($urandom), int'($urandom_range(1, 9)), int'($urandom_range(7, 12)), 1);
      chk_lvls(2, "rand_lvl");
      wait_pwm(2, int'($urandom_range(0, 20)));
    end
    setb(2, 8'h00);
    repeat (16) pulse(2, 8'h20, 8, 8, 0);
    chk("c_max", lvl(2, 5), 15);
    wait_pwm(2, 20);
    count_high(2, 5, 16, 15);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pwm_a", {29'b0, ifa.pwm_out}, 0);
    chk("arst_ps_a", {31'b0, ifa.period_start}, 0);
    chk("arst_lvl_a", {8'b0, ifa.level_out}, 0);
    chk("arst_lvl_b", {24'b0, ifb.level_out}, 0);
    chk("arst_pwm_c", {24'b0, ifc.pwm_out}, 0);
    chk("arst_lvl_c", ifc.level_out, 0);
    for (int s = 0; s < 3; s++) begin
      cur_a[s] = '0; cur_b[s] = '0; drive(s);
      for (int ch = 0; ch < 8; ch++) exp_lvl[s][ch] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(0);
    chk("arst_first_ps", {31'b0, ifa.period_start}, 1);
    chk_lvls(0, "arst_lvl_after");
    wait_pwm(0, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
